mb_booth_mult32: RTL and testbench
==================================

# mb_booth_mult32

Registered 32×32 signed multiplier built on radix-4 modified Booth recoding. Multiplicand `a` is recoded into 16 Booth digits, and each digit selects a partial product of `b`. The partial products are summed with a digit-dependent correction constant into a 64-bit two's-complement product. It is the arithmetic core of the 32-bit modified-Booth datapath and sits between operand registers and downstream consumers as a single-issue, fully pipelined unit.

## Interface
- No parameters; width fixed at 32×32→64.
- One clock; reset is synchronous and active-high.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operands valid this cycle.
- `a` in 32: multiplicand, signed two's complement; this is the recoded operand.
- `b` in 32: multiplier, signed two's complement.
- `out_valid` out 1: `product` valid.
- `product` out 64: signed a×b, exact (no overflow possible).

## Operation
- Booth digit i (i=0..15) uses triplet (a[2i+1], a[2i], a[2i-1]), with a[-1]=0:
  - `sign_i` = a[2i+1]
  - `one_i` = a[2i]^a[2i-1]
  - `two_i` = (a[2i+1]&~a[2i]&~a[2i-1]) | (~a[2i+1]&a[2i]&a[2i-1])
  - `neg_i` = sign_i & (one_i|two_i), so triplet 111 means +0, never −0.
- Partial product pp_i, 34 bits:
  - sel = b sign-extended to 34 bits if one_i; (b<<1) sign-extended to 34 bits if two_i; 0 otherwise.
  - pp_i = sel XOR {34{neg_i}}, then bit 33 inverted (sign-inversion trick).
  - 34 bits covers b=0x80000000 with digit ±2.
- Correction COR, 64 bits, a function of digits only:
  - COR = Σ neg_i·2^(2i) − Σ 2^(33+2i), all mod 2^64.
  - The first sum completes each two's-complement negation; the second removes the inverted sign bits.
- Product = Σ zero-extended(pp_i)·4^i + COR, mod 2^64. The result equals the exact signed 64-bit product.
- Zero digit: pp_i = 1<<33 (low bits 0), cancelled by COR.
- No handshake back-pressure. A new operand pair may be accepted every cycle.

## Timing
- Default latency is 1 cycle. Operands sampled at edge N with `in_valid`=1 give `product`/`out_valid`=1 after edge N (visible in cycle N+1).
- `out_valid` follows `in_valid` delayed by the latency.
- `product` holds its last value when `out_valid`=0.
- Reset values: `out_valid`=0, `product`=0, all internal pipeline registers cleared.
- `rst` asserted together with `in_valid`: reset wins and the operands are dropped.
- `rst` mid-flight: every in-flight operation is discarded, with no output for it.
- Back-to-back `in_valid` every cycle yields one result per cycle, in order.

## Configuration
- `MB_PP_PIPE_EN` defined: a register stage sits after digit recoding, partial-product generation and COR; the summation is in the following stage.
  - Latency 2 cycles, throughput still 1 per cycle.
  - `rst` clears both stages.
- Not defined: recoding, PP generation and sum are one combinational stage. Latency 1.

## Structure
- Shared package `mb_pkg`:
  - constants N=32, DIGITS=16, PPW=34
  - COR base constant (−Σ 2^(33+2i) mod 2^64)
  - typedef for the digit triple {sign, one, two}
- Natural sub-modules:
  - `mb_digit_enc`: per-digit recoder, instantiated 16×.
  - `mb_pp_sel`: per-digit 34-bit partial-product generator.
- COR generation and the 17-term adder stay in the top level.

## Test plan
- a=0x0E5482FC, b=0x2FC68201 → product=0x02ACA0B08BC07AFC, `out_valid` one cycle later (two with `MB_PP_PIPE_EN`).
- a=0x00000000, b=0xDEADBEEF → 0x0000000000000000; a=0xFFFFFFFF, b=0xFFFFFFFF → 0x0000000000000001.
- a=0x80000000, b=0x80000000 → 0x4000000000000000; a=0x7FFFFFFF, b=0x80000000 → 0xC000000080000000.
- a=0x00000005, b=0xFFFFFFFF → 0xFFFFFFFFFFFFFFFB; a=0xFFFFFFFF, b=0x00000005 → same result.
- Streaming: 1000 random pairs, one per cycle → each product matches $signed(a)*$signed(b), in order. Then a cycle with `rst`=1 and `in_valid`=1 → next cycle `out_valid`=0, `product`=0.

Source files
------------

// File: rtl/mb_pkg.sv
// Shared constants and types for the radix-4 modified-Booth 32x32 signed multiplier.
package mb_pkg;

    localparam int N      = 32;
    localparam int DIGITS = 16;
    localparam int PPW    = 34;

    // -(sum of 2^(33+2i), i=0..15) mod 2^64: removes the inverted sign bit of every partial product
    localparam logic [63:0] COR_BASE = 64'h5555_5556_0000_0000;

    typedef struct packed {
        logic sign;
        logic one;
        logic two;
    } booth_digit_t;

endpackage

// File: rtl/mb_digit_enc.sv
// Radix-4 Booth recoder for one digit: triplet {a[2i+1], a[2i], a[2i-1]} -> {sign, one, two}.
module mb_digit_enc
    import mb_pkg::*;
(
    input  logic [2:0]   trip,
    output booth_digit_t digit
);

    assign digit.sign = trip[2];
    assign digit.one  = trip[1] ^ trip[0];
    assign digit.two  = (trip[2] & ~trip[1] & ~trip[0]) | (~trip[2] & trip[1] & trip[0]);

endmodule

// File: rtl/mb_pp_sel.sv
// 34-bit partial-product generator for one Booth digit, with sign-bit inversion applied.
module mb_pp_sel
    import mb_pkg::*;
(
    input  booth_digit_t   digit,
    input  logic [N-1:0]   b,
    output logic [PPW-1:0] pp,
    output logic           neg
);

    logic [PPW-1:0] sel_s;

    // Select 0 / b / 2b, conditionally invert, then flip the top bit
    always_comb begin
        neg = digit.sign & (digit.one | digit.two);
        if (digit.one) begin
            sel_s = {{2{b[N-1]}}, b};
        end else if (digit.two) begin
            sel_s = {b[N-1], b, 1'b0};
        end else begin
            sel_s = {PPW{1'b0}};
        end
        pp          = sel_s ^ {PPW{neg}};
        pp[PPW-1]   = ~pp[PPW-1];
    end

endmodule

// File: rtl/mb_booth_mult32.sv
// Registered 32x32 -> 64 signed radix-4 Booth multiplier.
// Define MB_PP_PIPE_EN to register recoding/partial products/COR before the sum (latency 2).
module mb_booth_mult32
    import mb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    output logic          out_valid,
    output logic [63:0]   product
);

    logic [N:0]        a_ext_s;
    booth_digit_t      digit_s [DIGITS];
    logic [PPW-1:0]    pp_s    [DIGITS];
    logic [DIGITS-1:0] neg_s;
    logic [63:0]       cor_s;

    logic [PPW-1:0]    sum_pp_s [DIGITS];
    logic [63:0]       sum_cor_s;
    logic              sum_valid_s;
    logic [63:0]       sum_s;

    logic              out_valid_d, out_valid_q;
    logic [63:0]       product_d, product_q;

    assign a_ext_s = {a, 1'b0};

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        mb_digit_enc u_enc (
            .trip  (a_ext_s[2*g+2 -: 3]),
            .digit (digit_s[g])
        );
        mb_pp_sel u_pp (
            .digit (digit_s[g]),
            .b     (b),
            .pp    (pp_s[g]),
            .neg   (neg_s[g])
        );
    end

    // Negation completion bits sit at even positions below bit 32, where COR_BASE is zero
    always_comb begin
        cor_s = COR_BASE;
        for (int i = 0; i < DIGITS; i++) begin
            cor_s[2*i] = neg_s[i];
        end
    end

`ifdef MB_PP_PIPE_EN
    logic [PPW-1:0] pp_d [DIGITS];
    logic [PPW-1:0] pp_q [DIGITS];
    logic [63:0]    cor_d, cor_q;
    logic           pp_valid_d, pp_valid_q;

    // Next state of the partial-product stage
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            pp_d[i] = pp_s[i];
        end
        cor_d      = cor_s;
        pp_valid_d = in_valid;
    end

    // Partial-product stage register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                pp_q[i] <= {PPW{1'b0}};
            end
            cor_q      <= 64'd0;
            pp_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                pp_q[i] <= pp_d[i];
            end
            cor_q      <= cor_d;
            pp_valid_q <= pp_valid_d;
        end
    end

    // Summation stage reads the registered terms
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            sum_pp_s[i] = pp_q[i];
        end
        sum_cor_s   = cor_q;
        sum_valid_s = pp_valid_q;
    end
`else
    // Summation stage reads the combinational terms directly
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            sum_pp_s[i] = pp_s[i];
        end
        sum_cor_s   = cor_s;
        sum_valid_s = in_valid;
    end
`endif

    // 17-term sum: each partial product weighted by 4^i, plus the correction constant
    always_comb begin
        sum_s = sum_cor_s;
        for (int i = 0; i < DIGITS; i++) begin
            sum_s = sum_s + ({{(64-PPW){1'b0}}, sum_pp_s[i]} << (2*i));
        end
    end

    // Output stage next state: product holds while no new result arrives
    always_comb begin
        out_valid_d = sum_valid_s;
        if (sum_valid_s) begin
            product_d = sum_s;
        end else begin
            product_d = product_q;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            product_q   <= 64'd0;
        end else begin
            out_valid_q <= out_valid_d;
            product_q   <= product_d;
        end
    end

    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_mb_booth_mult32.sv
// Self-checking bench for mb_booth_mult32; honours MB_PP_PIPE_EN for the expected latency.
module tb_mb_booth_mult32;

`ifdef MB_PP_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [63:0] product;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [63:0] p;
    } ent_t;

    ent_t        pipe[$];
    logic        exp_valid;
    logic [63:0] exp_prod;

    mb_booth_mult32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        ent_t e;
        pipe.delete();
        e.v = 1'b0;
        e.p = 64'd0;
        for (int i = 0; i < LAT - 1; i++) pipe.push_back(e);
        exp_valid = 1'b0;
        exp_prod  = 64'd0;
    endtask

    // One clock: drive inputs, advance the reference model, compare outputs after the edge
    task automatic step(input logic r, input logic v, input logic [31:0] aa,
                        input logic [31:0] bb, input string tag);
        ent_t e;
        rst      = r;
        in_valid = v;
        a        = aa;
        b        = bb;
        e.v = v;
        e.p = longint'($signed(aa)) * longint'($signed(bb));
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            pipe.push_back(e);
            e = pipe.pop_front();
            exp_valid = e.v;
            if (e.v) exp_prod = e.p;
        end
        checks++;
        if (out_valid !== exp_valid) begin
            errors++;
            $display("FAIL %s out_valid: got %0b expected %0b", tag, out_valid, exp_valid);
        end
        checks++;
        if (product !== exp_prod) begin
            errors++;
            $display("FAIL %s product: got %h expected %h", tag, product, exp_prod);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, $urandom(), $urandom(), "reset");
        step(1'b0, 1'b0, $urandom(), $urandom(), "reset_idle");
    endtask

    task automatic test_directed();
        logic [31:0] ta [7];
        logic [31:0] tb [7];
        logic [63:0] tp [7];
        ta = '{32'h0E5482FC, 32'h00000000, 32'hFFFFFFFF, 32'h80000000,
               32'h7FFFFFFF, 32'h00000005, 32'hFFFFFFFF};
        tb = '{32'h2FC68201, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h80000000,
               32'h80000000, 32'hFFFFFFFF, 32'h00000005};
        tp = '{64'h02ACA0B08BC07AFC, 64'h0000000000000000, 64'h0000000000000001,
               64'h4000000000000000, 64'hC000000080000000, 64'hFFFFFFFFFFFFFFFB,
               64'hFFFFFFFFFFFFFFFB};
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 1'b1, ta[k], tb[k], "directed_issue");
            for (int j = 0; j < LAT - 1; j++) step(1'b0, 1'b0, $urandom(), $urandom(), "directed_wait");
            checks++;
            if (out_valid !== 1'b1 || product !== tp[k]) begin
                errors++;
                $display("FAIL directed_%0d: got valid=%0b product=%h expected valid=1 product=%h",
                         k, out_valid, product, tp[k]);
            end
        end
    endtask

    task automatic test_hold();
        step(1'b0, 1'b1, $urandom(), $urandom(), "hold_issue");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, $urandom(), $urandom(), "hold_idle");
    endtask

    function automatic logic [31:0] pick_operand();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 32'h80000000;
        else if (sel == 1) return 32'h7FFFFFFF;
        else if (sel == 2) return 32'hFFFFFFFF;
        else if (sel == 3) return 32'h00000000;
        else return $urandom();
    endfunction

    task automatic test_back_to_back();
        for (int i = 0; i < 1000; i++) step(1'b0, 1'b1, pick_operand(), pick_operand(), "stream");
        step(1'b1, 1'b1, $urandom(), $urandom(), "stream_rst");
        checks++;
        if (out_valid !== 1'b0 || product !== 64'd0) begin
            errors++;
            $display("FAIL rst_with_valid: got valid=%0b product=%h expected valid=0 product=0",
                     out_valid, product);
        end
        for (int i = 0; i < LAT + 1; i++) step(1'b0, 1'b0, $urandom(), $urandom(), "stream_drain");
    endtask

    task automatic test_midflight_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, $urandom(), $urandom(), "mid_issue");
        step(1'b1, 1'b0, $urandom(), $urandom(), "mid_rst");
        for (int i = 0; i < LAT + 1; i++) begin
            step(1'b0, 1'b0, $urandom(), $urandom(), "mid_after");
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midflight_discard: got valid=%0b expected 0", out_valid);
            end
        end
        for (int i = 0; i < 50; i++)
            step(1'b0, ($urandom_range(0, 2) != 0), $urandom(), $urandom(), "sparse");
        for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, $urandom(), $urandom(), "sparse_drain");
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 32'd0;
        b        = 32'd0;
        model_reset();
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_midflight_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
